// File: rtl/add8_bist.sv
`default_nettype none
// ============================================================================
// Module      : add8_bist
// Description : On-chip stimulus generator and response checker for an 8-bit
//               ripple adder. Drives four directed vectors followed by
//               LFSR-generated vectors, samples {cout, s} after a settle
//               window, compares against a+b+cin and tallies pass/fail.
//               Optional macro ADD8_BIST_STOP_ON_FAIL_EN ends the run at the
//               first mismatching vector.
// Revision    : 1.0 - initial release
// ============================================================================
module add8_bist #(
  parameter int          NUM_VEC = 64,
  parameter int          SETTLE  = 2,
  parameter logic [16:0] SEED    = 17'h1ACE5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  s,
  input  logic        cout,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic        cin,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic [33:0] first_fail
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);
  localparam logic [7:0]  SETTLE_C = 8'(SETTLE);
`ifdef ADD8_BIST_STOP_ON_FAIL_EN
  localparam logic        STOP_ON_FAIL = 1'b1;
`else
  localparam logic        STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [16:0] lfsr_q, lfsr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        cin_q, cin_d;
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic [33:0] first_fail_q, first_fail_d;

  logic [16:0] vec;
  logic [8:0]  golden;
  logic        match;

  // Vector source: directed table for the first four indices, LFSR after that
  always_comb begin
    vec = lfsr_q;
    unique case (idx_q)
      16'd0:   vec = {8'h00, 8'h00, 1'b0};
      16'd1:   vec = {8'hFF, 8'h01, 1'b0};
      16'd2:   vec = {8'hAA, 8'h55, 1'b0};
      16'd3:   vec = {8'hF0, 8'h0F, 1'b1};
      default: vec = lfsr_q;
    endcase
  end

  // Golden sum of the operands currently on the pins versus the adder response
  always_comb begin
    golden = {1'b0, a_q} + {1'b0, b_q} + {8'd0, cin_q};
    match  = (golden == {cout, s});
  end

  // Next-state and datapath update for the run sequencer
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_cnt_d   = 16'd0;
          fail_cnt_d   = 16'd0;
          first_fail_d = 34'd0;
          idx_d        = 16'd0;
          lfsr_d       = SEED;
          state_d      = S_APPLY;
        end
      end
      S_APPLY: begin
        {a_d, b_d, cin_d} = vec;
        cnt_d             = SETTLE_C;
        state_d           = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_d == 8'd0) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (match) begin
          if (pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 16'd1;
        end else begin
          if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
          if (fail_cnt_q == 16'd0) first_fail_d = {idx_q, a_q, b_q, cin_q};
        end
        // The LFSR must hold SEED through idx 3 so that idx 4 sees its first step
        if (idx_q >= 16'd3) lfsr_d = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
        if ((idx_q == LAST_IDX) || (STOP_ON_FAIL && !match)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 16'd0;
      lfsr_q       <= SEED;
      cnt_q        <= 8'd0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      cin_q        <= 1'b0;
      pass_cnt_q   <= 16'd0;
      fail_cnt_q   <= 16'd0;
      first_fail_q <= 34'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign cin        = cin_q;
  assign busy       = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (fail_cnt_q == 16'd0);
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_add8_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_add8_bist
// Description : Self-checking bench for add8_bist. Two instances (4 and 64
//               vectors) each drive a behavioural adder with selectable
//               faults; results are compared with a vector-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add8_bist;

  localparam int          S    = 2;
  localparam logic [16:0] SEED = 17'h1ACE5;
`ifdef ADD8_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, go, sel;
  int   fault_kind, fault_bit;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Adder under test model: 0 = correct, 1 = cout stuck at 0, 2 = s[bit] stuck at 1
  function automatic logic [8:0] adder_resp(input logic [7:0] a, input logic [7:0] b,
                                            input logic c, input int kind, input int bitn);
    logic [8:0] r;
    r = {1'b0, a} + {1'b0, b} + {8'd0, c};
    if (kind == 1) r[8] = 1'b0;
    else if (kind == 2) r[bitn] = 1'b1;
    return r;
  endfunction

  logic        start4, start64;
  logic [7:0]  a4, b4, s4, a64, b64, s64;
  logic        cin4, cout4, busy4, done4, pass4;
  logic        cin64, cout64, busy64, done64, pass64;
  logic [15:0] pc4, fc4, pc64, fc64;
  logic [33:0] ff4, ff64;

  assign start4  = go & ~sel;
  assign start64 = go & sel;
  assign {cout4, s4}   = adder_resp(a4, b4, cin4, fault_kind, fault_bit);
  assign {cout64, s64} = adder_resp(a64, b64, cin64, fault_kind, fault_bit);

  add8_bist #(.NUM_VEC(4), .SETTLE(S), .SEED(SEED)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .s(s4), .cout(cout4),
    .a(a4), .b(b4), .cin(cin4), .busy(busy4), .done(done4), .pass(pass4),
    .pass_cnt(pc4), .fail_cnt(fc4), .first_fail(ff4));

  add8_bist #(.NUM_VEC(64), .SETTLE(S), .SEED(SEED)) u_dut64 (
    .clk(clk), .rst(rst), .start(start64), .s(s64), .cout(cout64),
    .a(a64), .b(b64), .cin(cin64), .busy(busy64), .done(done64), .pass(pass64),
    .pass_cnt(pc64), .fail_cnt(fc64), .first_fail(ff64));

  logic [16:0] o_vec;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_pc, o_fc;
  logic [33:0] o_ff;
  assign o_vec  = sel ? {a64, b64, cin64} : {a4, b4, cin4};
  assign o_busy = sel ? busy64 : busy4;
  assign o_done = sel ? done64 : done4;
  assign o_pass = sel ? pass64 : pass4;
  assign o_pc   = sel ? pc64 : pc4;
  assign o_fc   = sel ? fc64 : fc4;
  assign o_ff   = sel ? ff64 : ff4;

  // ---------------- reference model ----------------
  function automatic logic [16:0] lfsr_step(input logic [16:0] q);
    return {q[15:0], q[16] ^ q[13]};
  endfunction

  // {a, b, cin} of vector idx
  function automatic logic [16:0] vec_of(input int idx);
    logic [16:0] q;
    case (idx)
      0: return {8'h00, 8'h00, 1'b0};
      1: return {8'hFF, 8'h01, 1'b0};
      2: return {8'hAA, 8'h55, 1'b0};
      3: return {8'hF0, 8'h0F, 1'b1};
      default: begin
        q = SEED;
        for (int i = 4; i <= idx; i++) q = lfsr_step(q);
        return q;
      end
    endcase
  endfunction

  task automatic model_run(input int n, output int pc, output int fc,
                           output logic [33:0] ff, output int nv);
    logic [16:0] v;
    logic [8:0]  gold, got;
    pc = 0; fc = 0; ff = '0; nv = n;
    for (int i = 0; i < n; i++) begin
      v    = vec_of(i);
      gold = {1'b0, v[16:9]} + {1'b0, v[8:1]} + {8'd0, v[0]};
      got  = adder_resp(v[16:9], v[8:1], v[0], fault_kind, fault_bit);
      if (gold == got) pc++;
      else begin
        if (fc == 0) ff = {16'(i), v};
        fc++;
        if (STOP) begin
          nv = i + 1;
          break;
        end
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  // Start a run on the selected instance and check it end to end.
  // pulse_at > 0 re-pulses start that many cycles into the run.
  task automatic run_and_check(input string name, input int pulse_at);
    int n, pc, fc, nv, m, done_m, total, limit, k;
    logic [33:0] ff;
    n = sel ? 64 : 4;
    model_run(n, pc, fc, ff, nv);
    total = nv * (S + 2);
    limit = total + 8;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    m = 0;
    checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_pc !== 16'd0 || o_fc !== 16'd0 || o_ff !== 34'd0) begin
      errors++;
      $display("FAIL %s start_clear: busy=%b done=%b pc=%0d fc=%0d ff=%h, expected busy=1 done=0 zeros",
               name, o_busy, o_done, o_pc, o_fc, o_ff);
    end
    done_m = -1;
    while (done_m < 0 && m < limit) begin
      @(negedge clk);
      m++;
      go = (m == pulse_at);
      k  = m / (S + 2);
      if ((m % (S + 2)) == S + 1 && k < nv) begin
        checks++;
        if (o_vec !== vec_of(k)) begin
          errors++;
          $display("FAIL %s operands idx %0d: got %h expected %h", name, k, o_vec, vec_of(k));
        end
      end
      if (o_done === 1'b1) done_m = m;
    end
    go = 1'b0;
    checks++;
    if (done_m != total) begin
      errors++;
      $display("FAIL %s done_latency: got %0d expected %0d", name, done_m, total);
    end
    checks++;
    if (o_pc !== 16'(pc) || o_fc !== 16'(fc) || o_ff !== ff || o_pass !== (fc == 0) || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s results: pc=%0d fc=%0d ff=%h pass=%b busy=%b expected pc=%0d fc=%0d ff=%h pass=%b busy=0",
               name, o_pc, o_fc, o_ff, o_pass, o_busy, pc, fc, ff, fc == 0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (o_done !== 1'b1 || o_pc !== 16'(pc) || o_vec !== vec_of(nv - 1)) begin
      errors++;
      $display("FAIL %s done_hold: done=%b pc=%0d vec=%h expected done=1 pc=%0d vec=%h",
               name, o_done, o_pc, o_vec, pc, vec_of(nv - 1));
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      checks++;
      if (o_vec !== 17'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
          o_pc !== 16'd0 || o_fc !== 16'd0 || o_ff !== 34'd0) begin
        errors++;
        $display("FAIL reset inst%0d: vec=%h busy=%b done=%b pass=%b pc=%0d fc=%0d ff=%h expected all 0",
                 i, o_vec, o_busy, o_done, o_pass, o_pc, o_fc, o_ff);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_directed_good();
    sel = 1'b0; fault_kind = 0;
    run_and_check("directed_good", -1);
  endtask

  task automatic test_lfsr_run64();
    sel = 1'b1; fault_kind = 0;
    run_and_check("lfsr64_good", -1);
    sel = 1'b0;
  endtask

  task automatic test_stuck_cout();
    sel = 1'b0; fault_kind = 1;
    run_and_check("stuck_cout", -1);
  endtask

  // Previous run left failures behind; the restart must clear them
  task automatic test_restart_from_done();
    sel = 1'b0; fault_kind = 0;
    run_and_check("restart_done", -1);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; fault_kind = 0;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    repeat (9) @(negedge clk);   // WAIT of idx 2
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_vec !== 17'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
        o_pc !== 16'd0 || o_fc !== 16'd0 || o_ff !== 34'd0) begin
      errors++;
      $display("FAIL reset_mid: vec=%h busy=%b done=%b pass=%b pc=%0d fc=%0d ff=%h expected all 0",
               o_vec, o_busy, o_done, o_pass, o_pc, o_fc, o_ff);
    end
    rst = 1'b0;
    run_and_check("after_reset", -1);
  endtask

  task automatic test_start_while_busy();
    sel = 1'b0; fault_kind = 0;
    run_and_check("busy_start", $urandom_range(4 * (S + 2) - 2, 1));
    run_and_check("back_to_back", -1);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      sel        = 1'($urandom_range(1, 0));
      fault_kind = $urandom_range(2, 0);
      fault_bit  = $urandom_range(7, 0);
      n          = sel ? 64 : 4;
      repeat ($urandom_range(3, 0)) @(negedge clk);
      if ($urandom_range(1, 0) == 1) run_and_check("random_pulse", $urandom_range(n * (S + 2) - 2, 1));
      else run_and_check("random", -1);
    end
    sel = 1'b0; fault_kind = 0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; sel = 1'b0; fault_kind = 0; fault_bit = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_directed_good();
    test_lfsr_run64();
    test_stuck_cout();
    test_restart_from_done();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
